pulse_gen_array: RTL and testbench

PULSE_GEN_ARRAY -- requirements
Module: pulse_gen_array

---
 rtl/pulse_gen_pkg.sv | 13 +
 rtl/pulse_chan.sv | 106 ++++++++++
 rtl/pulse_gen_array.sv | 44 ++++
 tb/tb_pulse_gen_array.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared types and default sizing for the pulse generator array.
package pulse_gen_pkg;

  localparam int unsigned DefNch = 14;
  localparam int unsigned DefCw  = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDelay = 2'd1,
    StWidth = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_chan.sv
// One pulse channel: delay/width FSM with a down-counter and shadowed configuration.
module pulse_chan
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CW     = DefCw,
  parameter bit          RETRIG = 1'b0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          enable_i,
  input  logic          polarity_i,
  input  logic          cfg_we_i,
  input  logic [CW-1:0] cfg_delay_i,
  input  logic [CW-1:0] cfg_width_i,
  output logic          pulse_o,
  output logic          busy_o
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] shd_delay_q, shd_width_q;
  logic [CW-1:0] act_delay_q, act_width_q;
  logic          pending_q, pending_d;
  logic          pulse_q, busy_q;
  logic          idle, accept, xfer;

  assign idle   = (state_q == StIdle);
  assign accept = enable_i & start_i & (idle | RETRIG);
  // Active values only change while idle, so a running pulse always sees a consistent pair.
  assign xfer   = enable_i & idle & pending_q & ~accept;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = cfg_we_i | (pending_q & ~xfer);
    if (!enable_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (accept) begin
      if (act_delay_q != '0) begin
        state_d = StDelay;
        cnt_d   = act_delay_q;
      end else if (act_width_q != '0) begin
        state_d = StWidth;
        cnt_d   = act_width_q;
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end else begin
      unique case (state_q)
        StDelay: begin
          if (cnt_q <= CW'(1)) begin
            state_d = (act_width_q != '0) ? StWidth : StIdle;
            cnt_d   = act_width_q;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        StWidth: begin
          if (cnt_q <= CW'(1)) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shd_delay_q <= '0;
      shd_width_q <= '0;
      act_delay_q <= '0;
      act_width_q <= '0;
      pending_q   <= 1'b0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      if (cfg_we_i) begin
        shd_delay_q <= cfg_delay_i;
        shd_width_q <= cfg_width_i;
      end
      if (xfer) begin
        act_delay_q <= shd_delay_q;
        act_width_q <= shd_width_q;
      end
      // A retrigger or disable drops the output to its inactive level on this edge.
      pulse_q <= ((state_q == StWidth) & enable_i & ~accept) ^ polarity_i;
      busy_q  <= (state_q != StIdle) & enable_i;
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/pulse_gen_array.sv
// Array of independent pulse channels sharing one configuration write port.
module pulse_gen_array
  import pulse_gen_pkg::*;
#(
  parameter int unsigned NCH    = DefNch,
  parameter int unsigned CW     = DefCw,
  parameter int unsigned RETRIG = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] start,
  input  logic           cfg_we,
  input  logic [4:0]     cfg_sel,
  input  logic [CW-1:0]  cfg_delay,
  input  logic [CW-1:0]  cfg_width,
  input  logic [NCH-1:0] polarity,
  input  logic [NCH-1:0] enable,
  output logic [NCH-1:0] pulse,
  output logic [NCH-1:0] busy
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic we;
    // Indices at or above NCH match no channel and are dropped.
    assign we = cfg_we & (cfg_sel == 5'(i));

    pulse_chan #(
      .CW     (CW),
      .RETRIG (RETRIG != 0)
    ) u_chan (
      .clk_i       (clk),
      .rst_i       (reset),
      .start_i     (start[i]),
      .enable_i    (enable[i]),
      .polarity_i  (polarity[i]),
      .cfg_we_i    (we),
      .cfg_delay_i (cfg_delay),
      .cfg_width_i (cfg_width),
      .pulse_o     (pulse[i]),
      .busy_o      (busy[i])
    );
  end

endmodule

// File: tb/tb_pulse_gen_array.sv
// Directed bench for pulse_gen_array; expectations are queued per edge and checked on arrival.
module tb_pulse_gen_array;

  localparam int unsigned NCH = 14;
  localparam int unsigned CW  = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] start, polarity, enable;
  logic           cfg_we;
  logic [4:0]     cfg_sel;
  logic [CW-1:0]  cfg_delay, cfg_width;
  logic [NCH-1:0] pulse0, busy0, pulse1, busy1;

  typedef struct {
    int   cyc;
    int   inst;
    int   ch;
    logic pulse;
    logic busy;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   ntests = 0;
  int   nfail  = 0;

  always #5 clk = ~clk;

  pulse_gen_array #(.NCH(NCH), .CW(CW), .RETRIG(0)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .polarity(polarity), .enable(enable),
    .pulse(pulse0), .busy(busy0)
  );

  pulse_gen_array #(.NCH(NCH), .CW(CW), .RETRIG(1)) dut_rt (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .polarity(polarity), .enable(enable),
    .pulse(pulse1), .busy(busy1)
  );

  task automatic check_vec(string tag, logic [NCH-1:0] obs, logic [NCH-1:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(string tag, logic obs, logic exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(exp_t e);
    int k;
    k = sb.size();
    while (k > 0 && sb[k-1].cyc > e.cyc) k--;
    sb.insert(k, e);
  endtask

  // Expected pulse/busy for one channel over edges t0..t1; empty ranges use lo > hi.
  task automatic exp_window(int inst, int ch, int t0, int t1, int p_lo, int p_hi,
                            int b_lo, int b_hi, logic pol);
    exp_t e;
    for (int c = t0; c <= t1; c++) begin
      e.cyc   = c;
      e.inst  = inst;
      e.ch    = ch;
      e.pulse = ((c >= p_lo) && (c <= p_hi)) ^ pol;
      e.busy  = (c >= b_lo) && (c <= b_hi);
      push(e);
    end
  endtask

  task automatic tick();
    exp_t           e;
    logic [NCH-1:0] p, b;
    string          tag;
    @(posedge clk);
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      p   = (e.inst == 1) ? pulse1 : pulse0;
      b   = (e.inst == 1) ? busy1 : busy0;
      tag = $sformatf("inst%0d ch%0d edge%0d", e.inst, e.ch, e.cyc);
      check_bit({tag, " pulse"}, p[e.ch], e.pulse);
      check_bit({tag, " busy"}, b[e.ch], e.busy);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      tick();
      guard++;
    end
  endtask

  task automatic cfg(int ch, int d, int w);
    cfg_we    = 1'b1;
    cfg_sel   = 5'(ch);
    cfg_delay = CW'(d);
    cfg_width = CW'(w);
    tick();
    cfg_we    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, e_dis;
    reset     = 1'b1;
    start     = '0;
    polarity  = 14'h0081;
    enable    = '1;
    cfg_we    = 1'b0;
    cfg_sel   = '0;
    cfg_delay = '0;
    cfg_width = '0;

    // Reset state and first edge after release.
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset pulse", pulse0, '0);
    check_vec("reset busy", busy0, '0);
    check_vec("reset pulse rt", pulse1, '0);
    reset = 1'b0;
    tick();
    check_vec("release pulse", pulse0, 14'h0081);
    check_vec("release busy", busy0, '0);

    // Polarity change is visible one edge later.
    polarity = 14'h0001;
    tick();
    check_vec("polarity change", pulse0, 14'h0001);

    // ch3 D=5 W=3.
    cfg(3, 5, 3);
    tick();
    t = cyc + 1;
    exp_window(0, 3, t, t + 10, t + 6, t + 8, t + 1, t + 8, 1'b0);
    start[3] = 1'b1;
    tick();
    start = '0;
    drain();

    // ch0 D=0 W=1, active-low.
    cfg(0, 0, 1);
    tick();
    t = cyc + 1;
    exp_window(0, 0, t, t + 4, t + 1, t + 1, t + 1, t + 1, 1'b1);
    start[0] = 1'b1;
    tick();
    start = '0;
    drain();

    // ch2 D=10 W=2, second start four edges later; both retrigger modes.
    cfg(2, 10, 2);
    tick();
    t = cyc + 1;
    exp_window(0, 2, t, t + 18, t + 11, t + 12, t + 1, t + 12, 1'b0);
    exp_window(1, 2, t, t + 18, t + 15, t + 16, t + 1, t + 16, 1'b0);
    start[2] = 1'b1;
    tick();
    start = '0;
    repeat (3) tick();
    start[2] = 1'b1;
    tick();
    start = '0;
    drain();

    // ch5: reconfigured twice mid-pulse; only the last write reaches the next pulse.
    cfg(5, 4, 4);
    tick();
    t = cyc + 1;
    exp_window(0, 5, t, t + 19, t + 5, t + 8, t + 1, t + 8, 1'b0);
    exp_window(0, 5, t + 20, t + 24, t + 22, t + 22, t + 21, t + 22, 1'b0);
    start[5] = 1'b1;
    tick();
    start = '0;
    tick();
    cfg(5, 9, 9);
    cfg(5, 1, 1);
    while (cyc < t + 19) tick();
    start[5] = 1'b1;
    tick();
    start = '0;
    drain();

    // ch1 disabled mid-width; starts ignored while disabled.
    cfg(1, 2, 6);
    tick();
    t     = cyc + 1;
    e_dis = t + 4;
    exp_window(0, 1, t, t + 3, t + 3, t + 8, t + 1, t + 8, 1'b0);
    exp_window(0, 1, e_dis + 1, e_dis + 4, 1, 0, 1, 0, 1'b0);
    start[1] = 1'b1;
    tick();
    start = '0;
    repeat (3) tick();
    enable[1] = 1'b0;
    repeat (2) tick();
    start[1] = 1'b1;
    tick();
    start = '0;
    drain();
    enable[1] = 1'b1;

    // Out-of-range select leaves every channel untouched.
    cfg(20, 1, 1);
    tick();
    t = cyc + 1;
    exp_window(0, 1, t, t + 10, t + 3, t + 8, t + 1, t + 8, 1'b0);
    exp_window(0, 4, t, t + 10, 1, 0, 1, 0, 1'b0);
    start[1] = 1'b1;
    start[4] = 1'b1;
    tick();
    start = '0;
    drain();

    // Asynchronous reset mid-delay.
    polarity = 14'h2A5A;
    repeat (2) tick();
    start[2] = 1'b1;
    start[3] = 1'b1;
    tick();
    start = '0;
    repeat (2) tick();
    check_vec("pre-reset busy", busy0, 14'h000C);
    #2;
    reset = 1'b1;
    #1;
    check_vec("async reset pulse", pulse0, '0);
    check_vec("async reset busy", busy0, '0);
    check_vec("async reset pulse rt", pulse1, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check_vec("post-reset pulse", pulse0, 14'h2A5A);
    check_vec("post-reset busy", busy0, '0);

    ntests++;
    assert (sb.size() == 0) else begin
      nfail++;
      $error("FAIL scoreboard leftover: observed %0d expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
